// File: rtl/vedic_pkg.sv
// Shared sizing helpers and operand magnitude function for the pipelined Vedic multiplier.
package vedic_pkg;

    localparam int unsigned MaxW = 64;

    function automatic int unsigned half_w(input int unsigned w);
        return w / 2;
    endfunction

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

    function automatic bit width_ok(input int unsigned w);
        return (w >= 4) && (w <= MaxW) && ((w & (w - 1)) == 0);
    endfunction

    // Operates on a zero-extended value; only the low 'width' bits are meaningful.
    function automatic logic [MaxW-1:0] abs_mag(input logic [MaxW-1:0] value,
                                                input logic            signed_mode,
                                                input int unsigned     width);
        logic [MaxW-1:0] mask;
        mask = {MaxW{1'b1}} >> (MaxW - width);
        if (signed_mode && value[width-1]) begin
            return (~value + MaxW'(1)) & mask;
        end
        return value & mask;
    endfunction

endpackage

// File: rtl/vedic_core.sv
// Combinational recursive N x N unsigned Urdhva-Tiryagbhyam multiplier.
module vedic_core #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    if (N == 2) begin : g_base
        logic pp00, pp10, pp01, pp11, c1;
        assign pp00 = a[0] & b[0];
        assign pp10 = a[1] & b[0];
        assign pp01 = a[0] & b[1];
        assign pp11 = a[1] & b[1];
        assign c1   = pp10 & pp01;
        assign p    = {pp11 & c1, pp11 ^ c1, pp10 ^ pp01, pp00};
    end else begin : g_rec
        localparam int unsigned H = N / 2;
        logic [N-1:0] ll, hl, lh, hh;
        logic [N:0]   mid;

        vedic_core #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
        vedic_core #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
        vedic_core #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
        vedic_core #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));

        // ll and hh occupy disjoint bit ranges, so they concatenate instead of adding.
        assign mid = {1'b0, hl} + {1'b0, lh};
        assign p   = {hh, ll} + ({{(N - 1){1'b0}}, mid} << H);
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage Vedic multiplier with valid/ready handshake, per-op signed mode and tag.
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned HalfW = half_w(WIDTH);
    localparam int unsigned ProdW = prod_w(WIDTH);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("vedic_mult_pipe: WIDTH must be a power of two >= 4");
    end

    logic adv;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // S1: operand magnitudes and result sign
    logic [MaxW-1:0]  a_ext, b_ext, mag_a_ext, mag_b_ext;
    logic             unused_mag_hi;
    logic [WIDTH-1:0] mag_a_q, mag_b_q;
    logic             sign1_q, v1_q;
    logic [TAG_W-1:0] tag1_q;

    assign a_ext         = MaxW'(in_a);
    assign b_ext         = MaxW'(in_b);
    assign mag_a_ext     = abs_mag(a_ext, in_signed, WIDTH);
    assign mag_b_ext     = abs_mag(b_ext, in_signed, WIDTH);
    assign unused_mag_hi = ^{mag_a_ext >> WIDTH, mag_b_ext >> WIDTH};

    always_ff @(posedge clk) begin
        if (adv) begin
            mag_a_q <= mag_a_ext[WIDTH-1:0];
            mag_b_q <= mag_b_ext[WIDTH-1:0];
            sign1_q <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            tag1_q  <= in_tag;
        end
    end

    // S2: quadrant partial products
    logic [WIDTH-1:0] ll, hl, lh, hh;
    logic [WIDTH-1:0] ll_q, hl_q, lh_q, hh_q;
    logic             sign2_q, v2_q;
    logic [TAG_W-1:0] tag2_q;

    vedic_core #(.N(HalfW)) u_ll (
        .a(mag_a_q[HalfW-1:0]), .b(mag_b_q[HalfW-1:0]), .p(ll));
    vedic_core #(.N(HalfW)) u_hl (
        .a(mag_a_q[WIDTH-1:HalfW]), .b(mag_b_q[HalfW-1:0]), .p(hl));
    vedic_core #(.N(HalfW)) u_lh (
        .a(mag_a_q[HalfW-1:0]), .b(mag_b_q[WIDTH-1:HalfW]), .p(lh));
    vedic_core #(.N(HalfW)) u_hh (
        .a(mag_a_q[WIDTH-1:HalfW]), .b(mag_b_q[WIDTH-1:HalfW]), .p(hh));

    always_ff @(posedge clk) begin
        if (adv) begin
            ll_q    <= ll;
            hl_q    <= hl;
            lh_q    <= lh;
            hh_q    <= hh;
            sign2_q <= sign1_q;
            tag2_q  <= tag1_q;
        end
    end

    // S3: recombine and apply sign
    logic [WIDTH:0]   mid;
    logic [ProdW-1:0] p_mag, p_fin, out_p_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             v3_q;

    assign mid   = {1'b0, hl_q} + {1'b0, lh_q};
    assign p_mag = {hh_q, ll_q} + ({{(WIDTH - 1){1'b0}}, mid} << HalfW);
    assign p_fin = sign2_q ? (~p_mag + ProdW'(1)) : p_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            out_p_q   <= '0;
            out_tag_q <= '0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            // Output data only changes when a real product arrives.
            if (v2_q) begin
                out_p_q   <= p_fin;
                out_tag_q <= tag2_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign out_p     = out_p_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed self-checking bench for vedic_mult_pipe (WIDTH=8 main instance, WIDTH=16 sweep).
module tb_vedic_mult_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_signed = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_p;
    logic [3:0]  out_tag;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [15:0] w_in_a = '0;
    logic [15:0] w_in_b = '0;
    logic        w_in_signed = 1'b0;
    logic [3:0]  w_in_tag = '0;
    logic        w_out_valid;
    logic [31:0] w_out_p;
    logic [3:0]  w_out_tag;

    int checks = 0;
    int passes = 0;

    logic [7:0]  vec_a [0:15];
    logic [7:0]  vec_b [0:15];
    logic        vec_s [0:15];
    logic [3:0]  vec_t [0:15];
    logic        obs_v [0:15];
    logic [15:0] obs_p [0:15];
    logic [3:0]  obs_t [0:15];

    always #5 clk = ~clk;

    vedic_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag)
    );

    vedic_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_signed(w_in_signed), .in_tag(w_in_tag),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_p(w_out_p), .out_tag(w_out_tag)
    );

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                         input logic s);
        int sa, sb;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        return 16'(sa * sb);
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        return 32'(sa * sb);
    endfunction

    // Drives n vectors back-to-back with out_ready=1; records output 3 cycles after each.
    task automatic stream8(input int n);
        for (int c = 0; c < n + 3; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                obs_v[c-3] = out_valid;
                obs_p[c-3] = out_p;
                obs_t[c-3] = out_tag;
            end
            if (c < n) begin
                in_valid  = 1'b1;
                in_a      = vec_a[c];
                in_b      = vec_b[c];
                in_signed = vec_s[c];
                in_tag    = vec_t[c];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        else passes++;
        checks++;
        if (out_p !== 16'h0) $display("FAIL reset_out_p got=%h exp=0000", out_p);
        else passes++;
        checks++;
        if (out_tag !== 4'h0) $display("FAIL reset_out_tag got=%h exp=0", out_tag);
        else passes++;
        checks++;
        if (in_ready !== 1'b1 || w_in_ready !== 1'b1)
            $display("FAIL reset_in_ready got=%b/%b exp=1/1", in_ready, w_in_ready);
        else passes++;
    endtask

    task automatic test_unsigned_b2b();
        vec_a[0] = 8'd255; vec_b[0] = 8'd255; vec_s[0] = 1'b0; vec_t[0] = 4'd1;
        vec_a[1] = 8'd0;   vec_b[1] = 8'd200; vec_s[1] = 1'b0; vec_t[1] = 4'd2;
        stream8(2);
        checks++;
        if (obs_v[0] !== 1'b1 || obs_p[0] !== 16'hFE01)
            $display("FAIL u255x255 got v=%b p=%h exp v=1 p=fe01", obs_v[0], obs_p[0]);
        else passes++;
        checks++;
        if (obs_v[1] !== 1'b1 || obs_p[1] !== 16'h0000)
            $display("FAIL u0x200 got v=%b p=%h exp v=1 p=0000", obs_v[1], obs_p[1]);
        else passes++;
    endtask

    task automatic test_signed();
        logic [15:0] exp_p [0:2];
        vec_a[0] = 8'h80; vec_b[0] = 8'h80; vec_s[0] = 1'b1; vec_t[0] = 4'd5;
        vec_a[1] = 8'hFF; vec_b[1] = 8'h01; vec_s[1] = 1'b1; vec_t[1] = 4'd6;
        vec_a[2] = 8'h80; vec_b[2] = 8'h7F; vec_s[2] = 1'b1; vec_t[2] = 4'd7;
        exp_p[0] = 16'h4000;
        exp_p[1] = 16'hFFFF;
        exp_p[2] = 16'hC080;
        stream8(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_v[i] !== 1'b1 || obs_p[i] !== exp_p[i])
                $display("FAIL signed_%0d got v=%b p=%h exp v=1 p=%h", i, obs_v[i], obs_p[i],
                         exp_p[i]);
            else passes++;
        end
    endtask

    task automatic test_mixed_mode();
        vec_a[0] = 8'hFF; vec_b[0] = 8'h02; vec_s[0] = 1'b0; vec_t[0] = 4'd3;
        vec_a[1] = 8'hFF; vec_b[1] = 8'h02; vec_s[1] = 1'b1; vec_t[1] = 4'd4;
        stream8(2);
        checks++;
        if (obs_p[0] !== 16'h01FE || obs_t[0] !== 4'd3)
            $display("FAIL mixed_unsigned got p=%h t=%0d exp p=01fe t=3", obs_p[0], obs_t[0]);
        else passes++;
        checks++;
        if (obs_p[1] !== 16'hFFFE || obs_t[1] !== 4'd4)
            $display("FAIL mixed_signed got p=%h t=%0d exp p=fffe t=4", obs_p[1], obs_t[1]);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic [19:0] expq [$];
        logic [19:0] e;
        logic [15:0] prev_p;
        logic [3:0]  prev_t;
        logic        stalled = 1'b0;
        logic        need_new = 1'b1;
        int          sent = 0;
        int          got = 0;
        for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_p !== prev_p || out_tag !== prev_t)
                    $display("FAIL bp_stall_hold got v=%b p=%h t=%0d exp v=1 p=%h t=%0d",
                             out_valid, out_p, out_tag, prev_p, prev_t);
                else passes++;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                e = (expq.size() > 0) ? expq.pop_front() : 20'hxxxxx;
                checks++;
                if ({out_p, out_tag} !== e)
                    $display("FAIL bp_product_%0d got p=%h t=%0d exp p=%h t=%0d", got, out_p,
                             out_tag, e[19:4], e[3:0]);
                else passes++;
                got++;
            end
            stalled = out_valid && !out_ready;
            prev_p  = out_p;
            prev_t  = out_tag;
            if (sent < 10) begin
                if (need_new) begin
                    in_a      = 8'($urandom);
                    in_b      = 8'($urandom);
                    in_signed = 1'($urandom_range(0, 1));
                    in_tag    = 4'(sent + 1);
                end
                in_valid = 1'b1;
                #1;
                need_new = in_ready;
                if (in_ready) begin
                    expq.push_back({ref8(in_a, in_b, in_signed), in_tag});
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 10 || expq.size() !== 0)
            $display("FAIL bp_count got=%0d pending=%0d exp got=10 pending=0", got,
                     expq.size());
        else passes++;
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_no_extra got v=%b exp v=0", out_valid);
        else passes++;
    endtask

    task automatic test_reset_inflight();
        logic stale = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_a      = 8'(c + 3);
            in_b      = 8'd11;
            in_signed = 1'b0;
            in_tag    = 4'(c + 9);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_p !== 16'h0)
            $display("FAIL rst_inflight got v=%b p=%h exp v=0 p=0000", out_valid, out_p);
        else passes++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) $display("FAIL rst_no_stale got stale=%b exp=0", stale);
        else passes++;
        vec_a[0] = 8'd7; vec_b[0] = 8'd9; vec_s[0] = 1'b0; vec_t[0] = 4'd2;
        stream8(1);
        checks++;
        if (obs_v[0] !== 1'b1 || obs_p[0] !== 16'd63 || obs_t[0] !== 4'd2)
            $display("FAIL rst_first_op got v=%b p=%0d t=%0d exp v=1 p=63 t=2", obs_v[0],
                     obs_p[0], obs_t[0]);
        else passes++;
    endtask

    task automatic test_sweep16();
        logic [15:0] vals [0:4];
        logic [15:0] sa [0:49];
        logic [15:0] sb [0:49];
        logic        ss [0:49];
        logic [31:0] ex [0:49];
        int          k = 0;
        vals[0] = 16'h0000; vals[1] = 16'h0001; vals[2] = 16'hFFFF;
        vals[3] = 16'h8000; vals[4] = 16'h5555;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) begin
                    sa[k] = vals[i];
                    sb[k] = vals[j];
                    ss[k] = 1'(m);
                    ex[k] = ref16(vals[i], vals[j], 1'(m));
                    k++;
                end
        for (int c = 0; c < 53; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                checks++;
                if (w_out_valid !== 1'b1 || w_out_p !== ex[c-3] || w_out_tag !== 4'(c - 3))
                    $display("FAIL sweep16_%0d a=%h b=%h s=%b got v=%b p=%h t=%0d exp p=%h",
                             c - 3, sa[c-3], sb[c-3], ss[c-3], w_out_valid, w_out_p,
                             w_out_tag, ex[c-3]);
                else passes++;
            end
            if (c < 50) begin
                w_in_valid  = 1'b1;
                w_in_a      = sa[c];
                w_in_b      = sb[c];
                w_in_signed = ss[c];
                w_in_tag    = 4'(c);
            end else begin
                w_in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_b2b();
        test_signed();
        test_mixed_mode();
        test_backpressure();
        test_reset_inflight();
        test_sweep16();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
